// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS opcode/funct constants, ALU op encoding and the
//               decode-to-execute bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_NOR    = 4'd5,
        ALU_SLT    = 4'd6,
        ALU_SLTU   = 4'd7,
        ALU_SLL    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_SRA    = 4'd10,
        ALU_LUI    = 4'd11,
        ALU_PASS_B = 4'd12
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        alu_op_t     alu_op;
        logic        alu_src_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch_eq;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        logic        illegal;
    } id_bundle_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 32x32 register file, 2 read / 1 write, $0 hardwired to zero,
//               write-before-read bypass on both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);

    logic [31:0] r_mem [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_mem[i_raddr_a];
        o_rdata_b = r_mem[i_raddr_b];
        if (i_we && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
        if (i_we && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
        // Index 0 wins over the bypass so $0 can never be overridden.
        if (i_raddr_a == 5'd0) o_rdata_a = 32'h0;
        if (i_raddr_b == 5'd0) o_rdata_b = 32'h0;
    end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module      : decode
// Description : MIPS decode stage - cracks one instruction per accept into a
//               registered bundle with operands read from the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module decode
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_dest,
    output logic [4:0]  id_shamt,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_reg_we,
    output logic        id_mem_rd,
    output logic        id_mem_wr,
    output logic        id_branch_eq,
    output logic        id_branch_ne,
    output logic        id_jump,
    output logic        id_jump_reg,
    output logic        id_illegal,
    output logic [31:0] id_target
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm16;
    logic [31:0] w_sext;
    logic [31:0] w_pc4;
    logic [31:0] w_btgt;
    logic [31:0] w_jtgt;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_legal;
    logic        w_accept;
    id_bundle_t  w_dec;

    logic        r_valid;
    id_bundle_t  r_bun;

    assign w_op    = if_instr[31:26];
    assign w_rs    = if_instr[25:21];
    assign w_rt    = if_instr[20:16];
    assign w_rd    = if_instr[15:11];
    assign w_shamt = if_instr[10:6];
    assign w_funct = if_instr[5:0];
    assign w_imm16 = if_instr[15:0];
    assign w_sext  = sext16(w_imm16);
    assign w_pc4   = if_pc + 32'd4;
    assign w_btgt  = w_pc4 + {w_sext[29:0], 2'b00};
    assign w_jtgt  = {w_pc4[31:28], if_instr[25:0], 2'b00};

    regfile u_regfile (
        .clk       (CLK),
        .rst_n     (RST_N),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val)
    );

    always_comb begin
        w_legal          = 1'b1;
        w_dec            = '0;
        w_dec.pc         = if_pc;
        w_dec.rs_data    = w_rs_val;
        w_dec.rt_data    = w_rt_val;
        w_dec.imm        = w_sext;
        w_dec.alu_op     = ALU_ADD;
        case (w_op)
            c_OP_RTYPE: begin
                w_dec.dest  = w_rd;
                w_dec.shamt = w_shamt;
                case (w_funct)
                    c_FN_SLL:             w_dec.alu_op = ALU_SLL;
                    c_FN_SRL:             w_dec.alu_op = ALU_SRL;
                    c_FN_SRA:             w_dec.alu_op = ALU_SRA;
                    c_FN_ADD, c_FN_ADDU:  w_dec.alu_op = ALU_ADD;
                    c_FN_SUB, c_FN_SUBU:  w_dec.alu_op = ALU_SUB;
                    c_FN_AND:             w_dec.alu_op = ALU_AND;
                    c_FN_OR:              w_dec.alu_op = ALU_OR;
                    c_FN_XOR:             w_dec.alu_op = ALU_XOR;
                    c_FN_NOR:             w_dec.alu_op = ALU_NOR;
                    c_FN_SLT:             w_dec.alu_op = ALU_SLT;
                    c_FN_SLTU:            w_dec.alu_op = ALU_SLTU;
                    c_FN_JR: begin
                        w_dec.dest     = 5'd0;
                        w_dec.jump_reg = 1'b1;
                        w_dec.target   = w_rs_val;
                    end
                    default:              w_legal = 1'b0;
                endcase
            end
            c_OP_J: begin
                w_dec.jump   = 1'b1;
                w_dec.target = w_jtgt;
            end
            c_OP_JAL: begin
                w_dec.jump        = 1'b1;
                w_dec.target      = w_jtgt;
                w_dec.dest        = 5'd31;
                w_dec.imm         = if_pc + 32'd8;
                w_dec.alu_op      = ALU_PASS_B;
                w_dec.alu_src_imm = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_dec.branch_eq = (w_op == c_OP_BEQ);
                w_dec.branch_ne = (w_op == c_OP_BNE);
                w_dec.alu_op    = ALU_SUB;
                w_dec.target    = w_btgt;
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU, c_OP_LW: begin
                w_dec.dest        = w_rt;
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_rd      = (w_op == c_OP_LW);
                if (w_op == c_OP_SLTI)  w_dec.alu_op = ALU_SLT;
                if (w_op == c_OP_SLTIU) w_dec.alu_op = ALU_SLTU;
            end
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                w_dec.dest        = w_rt;
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm         = {16'h0, w_imm16};
                w_dec.alu_op      = (w_op == c_OP_ANDI) ? ALU_AND :
                                    (w_op == c_OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            c_OP_LUI: begin
                w_dec.dest        = w_rt;
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm         = {w_imm16, 16'h0};
                w_dec.alu_op      = ALU_LUI;
            end
            c_OP_SW: begin
                w_dec.mem_wr      = 1'b1;
                w_dec.alu_src_imm = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase

        // A $0 destination never writes, which also makes the all-zero NOP inert.
        w_dec.reg_we = w_legal && (w_dec.dest != 5'd0);

        if (!w_legal) begin
            w_dec.illegal     = 1'b1;
            w_dec.dest        = 5'd0;
            w_dec.mem_rd      = 1'b0;
            w_dec.mem_wr      = 1'b0;
            w_dec.branch_eq   = 1'b0;
            w_dec.branch_ne   = 1'b0;
            w_dec.jump        = 1'b0;
            w_dec.jump_reg    = 1'b0;
            w_dec.target      = 32'h0;
            w_dec.alu_op      = ALU_ADD;
            w_dec.alu_src_imm = 1'b0;
        end
    end

    assign id_ready = !r_valid || ex_ready;
    assign w_accept = if_valid && id_ready && !flush;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid  <= 1'b0;
            r_bun    <= '0;
            r_bun.pc <= RESET_PC;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_bun.pc <= RESET_PC;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bun    <= w_dec;
        end else if (r_valid && ex_ready) begin
            r_valid  <= 1'b0;
            r_bun.pc <= RESET_PC;
        end
    end

    assign id_valid       = r_valid;
    assign id_pc          = r_bun.pc;
    assign id_rs_data     = r_bun.rs_data;
    assign id_rt_data     = r_bun.rt_data;
    assign id_imm         = r_bun.imm;
    assign id_dest        = r_bun.dest;
    assign id_shamt       = r_bun.shamt;
    assign id_alu_op      = r_bun.alu_op;
    assign id_alu_src_imm = r_bun.alu_src_imm;
    assign id_reg_we      = r_bun.reg_we;
    assign id_mem_rd      = r_bun.mem_rd;
    assign id_mem_wr      = r_bun.mem_wr;
    assign id_branch_eq   = r_bun.branch_eq;
    assign id_branch_ne   = r_bun.branch_ne;
    assign id_jump        = r_bun.jump;
    assign id_jump_reg    = r_bun.jump_reg;
    assign id_illegal     = r_bun.illegal;
    assign id_target      = r_bun.target;

endmodule
`default_nettype wire

// File: doc/decode.md
# decode

Second stage of the MIPS pipeline, directly downstream of `fetch`. Accepts one fetched instruction plus its PC per handshake and cracks it into fields and control signals. Reads two operands from an internal 32×32 register file, which the writeback stage writes. Presents a registered decode bundle to the execute stage. Hazard detection and stall generation are outside this block; operands are sampled at accept time.

## Interface
Parameters
- `RESET_PC`, `32'h0000_0000`: value driven on `id_pc` while idle/after reset.

Ports
- `CLK`  in  1  single clock; all state on rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `if_valid`  in  1  fetch presents an instruction.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  address of `if_instr`.
- `id_ready`  out  1  decode can accept this cycle.
- `flush`  in  1  discard held and incoming instruction (branch/jump redirect).
- `wb_we`  in  1  register-file write enable.
- `wb_addr`  in  5  write register index.
- `wb_data`  in  32  write data.
- `ex_ready`  in  1  execute accepts the decode bundle.
- `id_valid`  out  1  decode bundle valid.
- `id_pc`  out  32  PC of decoded instruction.
- `id_rs_data`, `id_rt_data`  out  32 each  operand values.
- `id_imm`  out  32  extended immediate.
- `id_dest`  out  5  destination register.
- `id_shamt`  out  5  shift amount.
- `id_alu_op`  out  4  ALU operation code.
- `id_alu_src_imm`  out  1  ALU B operand is `id_imm`.
- `id_reg_we`, `id_mem_rd`, `id_mem_wr`, `id_branch_eq`, `id_branch_ne`, `id_jump`, `id_jump_reg`, `id_illegal`  out  1 each  control flags.
- `id_target`  out  32  branch or jump target.

## Operation
- Accept occurs when `if_valid && id_ready && !flush`. Output registers load decoded values and `id_valid` sets to 1.
- `id_ready = !id_valid || ex_ready`. This is a one-entry pipeline register with no skid.
- While `id_valid && !ex_ready`, every `id_*` output holds stable.
- Handoff to execute occurs when `id_valid && ex_ready`. With no new accept in the same cycle, `id_valid` clears.
- `flush` clears `id_valid` on the next edge and blocks any same-cycle accept. `flush` has priority over accept and over hold.
- Register file:
  - 32 entries; entry 0 reads as 0, and writes to it are ignored.
  - Writes are synchronous.
  - Write-before-read bypass: if `wb_we` and `wb_addr` equal a source index during an accept, the captured operand is `wb_data` (not for index 0).
- Supported instructions:
  - R-type: ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA JR.
  - I-type: ADDI ADDIU SLTI SLTIU ANDI ORI XORI LUI LW SW BEQ BNE.
  - J-type: J JAL.
- Immediate extension:
  - Zero-extended for ANDI/ORI/XORI.
  - LUI gives `{imm,16'h0}`.
  - All others are sign-extended.
- Destination register:
  - `rd` for R-type.
  - `rt` for I-type.
  - 31 for JAL.
  - 0 with `id_reg_we=0` for SW/BEQ/BNE/J/JR.
- Targets (all arithmetic mod 2^32):
  - Branches: `id_target = pc+4 + (sext(imm)<<2)`.
  - J/JAL: `id_target = {pc+4[31:28], instr[25:0], 2'b00}`.
  - JR: `id_target = rs_data`.
- JAL: ALU op `PASS_B` with `id_imm = pc+8`.
- Any undefined opcode or funct sets `id_illegal=1` and forces `id_reg_we`, `id_mem_rd`, `id_mem_wr`, branch and jump flags to 0.
- The all-zero word decodes as SLL $0,$0,0, a legal NOP with `id_reg_we=0`.

## Timing
- Latency: 1 cycle from accept edge to `id_valid`. Sustained throughput is 1 per cycle while `ex_ready=1`.
- Operands reflect register-file state at the accept edge, plus the same-cycle bypass. Later writebacks are not reflected in a held bundle.
- Reset (asynchronous, any time, including mid-hold):
  - `id_valid=0`.
  - `id_pc=RESET_PC`.
  - All other outputs 0.
  - All registers 0.
  - `id_ready` reads 1 as soon as reset deasserts.
- Simultaneous handoff and accept: the new bundle replaces the old one and `id_valid` stays 1.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants.
  - Funct constants.
  - `alu_op_t` with encodings ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, PASS_B=12.
- Sub-module `regfile`: 2 read ports, 1 write port, $0 hardwired, with internal bypass. Decode logic stays combinational in `decode` ahead of the output register.

## Test plan
- Write $8=0x10 via writeback, then accept `0x21080005` (ADDI $8,$8,5). Next cycle requires `id_valid=1`, `id_rs_data=0x10`, `id_imm=5`, `id_dest=8`, `id_alu_op=ADD`, `id_alu_src_imm=1`, `id_reg_we=1`.
- `wb_we=1`, `wb_addr=9`, `wb_data=0xABCD` in the same cycle as accepting `0x01294820` (ADD $9,$9,$9) requires `id_rs_data=id_rt_data=0xABCD`. A write of 0xFFFFFFFF to $0, followed by any read of $0, returns 0.
- Hold `ex_ready=0` with a bundle valid and present a second instruction. Requires `id_ready=0` and outputs stable for 3 cycles. After `ex_ready=1`, the second instruction appears on the following cycle.
- J `0x08000100` at pc 0x0040_0010 gives `id_target=0x0000_0400`, `id_jump=1`. BEQ imm 0xFFFF at pc 0x100 gives `id_target=0x100`. JAL at pc 0x20 gives `id_dest=31`, `id_imm=0x28`.
- Opcode 0x3F gives `id_illegal=1` and all write/mem/branch flags 0. `flush` asserted with `if_valid=1` gives `id_valid=0` next cycle.
- Drop `RST_N` mid-hold: all outputs clear asynchronously, `id_pc=RESET_PC`, and previously written registers read 0 afterward.
